// File: rtl/sram_arbiter.sv
// Single-port scheduler for the external SRAM, shared by screen fetch, CPU and aux requesters.
// Runs fixed-length strobed accesses, pulses one-cycle acks and guards the aux port against starvation.
module sram_arbiter #(
    parameter int unsigned ACC_CYCLES   = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        scr_req,
    input  logic [18:0] scr_addr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        aux_req,
    input  logic        aux_we,
    input  logic [18:0] aux_addr,
    input  logic [7:0]  aux_wdata,
    output logic        scr_ack,
    output logic        cpu_ack,
    output logic        aux_ack,
    output logic [7:0]  rdata,
    output logic        cpu_wait,
    output logic [18:0] va,
    input  logic [7:0]  vd_in,
    output logic [7:0]  vd_out,
    output logic        vd_oe,
    output logic        n_vrd,
    output logic        n_vwr
);
    localparam logic [2:0] ACC_LOAD   = 3'(ACC_CYCLES);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;
    typedef enum logic [1:0] {OWN_SCR, OWN_CPU, OWN_AUX} owner_t;

    state_t      state_q, state_d;
    owner_t      owner_q, owner_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [3:0]  starve_q, starve_d;
    logic        scr_ack_q, cpu_ack_q, aux_ack_q;
    logic        scr_ack_d, cpu_ack_d, aux_ack_d;
    logic        aux_grant;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        scr_ack_d = 1'b0;
        cpu_ack_d = 1'b0;
        aux_ack_d = 1'b0;
        aux_grant = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (scr_req) begin
                    owner_d = OWN_SCR;
                    we_d    = 1'b0;
                    addr_d  = scr_addr;
                    state_d = ACCESS;
                end else if (aux_req && (starve_q == STARVE_MAX || !cpu_req)) begin
                    // A starved aux outranks the CPU; otherwise it only gets idle slots.
                    owner_d   = OWN_AUX;
                    we_d      = aux_we;
                    addr_d    = aux_addr;
                    wdata_d   = aux_wdata;
                    aux_grant = 1'b1;
                    state_d   = ACCESS;
                end else if (cpu_req) begin
                    owner_d = OWN_CPU;
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = ACCESS;
                end
                if (state_d == ACCESS) cnt_d = ACC_LOAD;
            end
            ACCESS: begin
                if (cnt_q == 3'd1) begin
                    state_d   = we_q ? RECOVER : IDLE;
                    if (!we_q) rdata_d = vd_in;
                    scr_ack_d = (owner_q == OWN_SCR);
                    cpu_ack_d = (owner_q == OWN_CPU);
                    aux_ack_d = (owner_q == OWN_AUX);
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        starve_d = starve_q;
        if (!aux_req || aux_grant) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= OWN_SCR;
            cnt_q     <= 3'd0;
            we_q      <= 1'b0;
            addr_q    <= 19'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            starve_q  <= 4'd0;
            scr_ack_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            aux_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            starve_q  <= starve_d;
            scr_ack_q <= scr_ack_d;
            cpu_ack_q <= cpu_ack_d;
            aux_ack_q <= aux_ack_d;
        end
    end

    assign scr_ack  = scr_ack_q;
    assign cpu_ack  = cpu_ack_q;
    assign aux_ack  = aux_ack_q;
    assign rdata    = rdata_q;
    assign cpu_wait = cpu_req & ~cpu_ack_q;
    assign va       = addr_q;
    assign vd_out   = wdata_q;
    // Output enable stays up through RECOVER so write data is held past the strobe.
    assign vd_oe    = we_q && (state_q != IDLE);
    assign n_vrd    = !(state_q == ACCESS && !we_q);
    assign n_vwr    = !(state_q == ACCESS && we_q);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: timeline model of grants/acks checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_sram_arbiter;
    localparam int N = 2;
    localparam int L = 8;

    logic        clk28 = 1'b0;
    logic        rst_n;
    logic        scr_req, cpu_req, cpu_we, aux_req, aux_we;
    logic [18:0] scr_addr, cpu_addr, aux_addr;
    logic [7:0]  cpu_wdata, aux_wdata;
    logic        scr_ack, cpu_ack, aux_ack, cpu_wait, vd_oe, n_vrd, n_vwr;
    logic [7:0]  rdata, vd_in, vd_out;
    logic [18:0] va;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit cpu_hold = 1'b0;

    always #5 clk28 = ~clk28;

    sram_arbiter #(.ACC_CYCLES(N), .STARVE_LIMIT(L)) dut (
        .clk28(clk28), .rst_n(rst_n),
        .scr_req(scr_req), .scr_addr(scr_addr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .scr_ack(scr_ack), .cpu_ack(cpu_ack), .aux_ack(aux_ack),
        .rdata(rdata), .cpu_wait(cpu_wait), .va(va), .vd_in(vd_in),
        .vd_out(vd_out), .vd_oe(vd_oe), .n_vrd(n_vrd), .n_vwr(n_vwr)
    );

    // Initial SRAM contents, a fixed pattern with one planted byte.
    function automatic logic [7:0] init_val(input logic [18:0] a);
        if (a == 19'h1C000) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    logic [7:0] sram    [0:524287];
    bit         written [0:524287];
    always @(posedge clk28) begin
        if (!n_vwr) begin
            sram[va]    <= vd_out;
            written[va] <= 1'b1;
        end
    end
    assign vd_in = written[va] ? sram[va] : init_val(va);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  mem_e [int];
    int          m_owner = -1;   // -1 none, 0 scr, 1 cpu, 2 aux
    int          m_g = 0;
    bit          m_we = 1'b0;
    logic [18:0] m_addr;
    logic [18:0] va_e = 19'd0;
    logic [7:0]  vd_e = 8'd0;
    logic [7:0]  rdata_e = 8'd0;
    int          starve_e = 0;
    int          mc = 0;
    bit          prev_rst = 1'b1;
    int          ph, w;
    bit          acc, rec, done, idle, oe_e;

    function automatic logic [7:0] mem_rd(input logic [18:0] a);
        return mem_e.exists(int'(a)) ? mem_e[int'(a)] : init_val(a);
    endfunction

    initial begin
        @(posedge clk28);
        forever begin
            @(negedge clk28);
            ph   = mc - m_g;
            acc  = (m_owner >= 0) && ph >= 1 && ph <= N;
            rec  = (m_owner >= 0) && m_we && ph == N + 1;
            done = (m_owner >= 0) && ph == N + 1;
            idle = (m_owner < 0) || ph >= (m_we ? N + 2 : N + 1);
            oe_e = (m_owner >= 0) && m_we && (acc || rec);
            if (done && !m_we) rdata_e = mem_rd(m_addr);

            check("m_scr_ack", scr_ack, done && m_owner == 0);
            check("m_cpu_ack", cpu_ack, done && m_owner == 1);
            check("m_aux_ack", aux_ack, done && m_owner == 2);
            check("m_n_vrd", n_vrd, !(acc && !m_we));
            check("m_n_vwr", n_vwr, !(acc && m_we));
            check("m_vd_oe", vd_oe, oe_e);
            check("m_va", va, va_e);
            check("m_rdata", rdata, rdata_e);
            check("m_cpu_wait", cpu_wait, cpu_req && !(done && m_owner == 1));
            if (oe_e || prev_rst) check("m_vd_out", vd_out, vd_e);

            prev_rst = !rst_n;
            if (!rst_n) begin
                m_owner  = -1;
                starve_e = 0;
                va_e     = 19'd0;
                vd_e     = 8'd0;
                rdata_e  = 8'd0;
            end else begin
                w = -1;
                if (idle) begin
                    if (scr_req) w = 0;
                    else if (aux_req && starve_e == L) w = 2;
                    else if (cpu_req) w = 1;
                    else if (aux_req) w = 2;
                end
                if (w >= 0) begin
                    m_owner = w;
                    m_g     = mc;
                    m_we    = (w == 1) ? cpu_we : (w == 2) ? aux_we : 1'b0;
                    m_addr  = (w == 0) ? scr_addr : (w == 1) ? cpu_addr : aux_addr;
                    va_e    = m_addr;
                    if (m_we) begin
                        vd_e = (w == 1) ? cpu_wdata : aux_wdata;
                        mem_e[int'(m_addr)] = vd_e;
                    end
                end
                starve_e = (aux_req && w != 2) ? ((starve_e + 1 > L) ? L : starve_e + 1) : 0;
            end
            mc++;
        end
    end

    // ---------------- stimulus ----------------
    // Requesters drop their request on seeing the ack, unless held.
    task automatic tick();
        @(posedge clk28);
        #1;
        cyc++;
        if (scr_ack) scr_req = 1'b0;
        if (cpu_ack && !cpu_hold) cpu_req = 1'b0;
        if (aux_ack) aux_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        scr_req = 1'b1; scr_addr = 19'h00100;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00200; cpu_wdata = 8'h00;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 19'h00300; aux_wdata = 8'h00;

        // Reset held with all requests high.
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk28);
            check("rst_n_vrd", n_vrd, 1'b1);
            check("rst_vd_oe", vd_oe, 1'b0);
            check("rst_va", va, 19'h0);
            check("rst_acks", {scr_ack, cpu_ack, aux_ack}, 3'b000);
        end

        // Release: simultaneous scr/cpu/aux reads.
        tick();
        rst_n = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) tick();
            @(negedge clk28);
            if (k == 1) check("sim_scr_first", va, 19'h00100);
            if (k == 1) check("sim_n_vrd", n_vrd, 1'b0);
            if (k == 3) check("sim_scr_ack", scr_ack, 1'b1);
            if (k == 3) check("sim_scr_rdata", rdata, 8'h5B);
            if (k == 4) check("sim_cpu_va", va, 19'h00200);
            if (k == 6) check("sim_cpu_ack", cpu_ack, 1'b1);
            if (k == 6) check("sim_cpu_rdata", rdata, 8'h58);
            if (k == 9) check("sim_aux_ack", aux_ack, 1'b1);
            if (k == 9) check("sim_aux_rdata", rdata, 8'h59);
        end

        // Single CPU read.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h1C000;
        for (int k = 0; k <= 4; k++) begin
            if (k > 0) tick();
            @(negedge clk28);
            if (k <= 2) check("rd_cpu_wait", cpu_wait, 1'b1);
            if (k == 1 || k == 2) check("rd_n_vrd", n_vrd, 1'b0);
            if (k == 3) check("rd_cpu_ack", cpu_ack, 1'b1);
            if (k == 3) check("rd_rdata", rdata, 8'hA5);
            if (k == 3) check("rd_wait_end", cpu_wait, 1'b0);
            if (k == 4) check("rd_n_vrd_idle", n_vrd, 1'b1);
        end

        // CPU write followed by a screen read of the same address.
        tick();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h04000; cpu_wdata = 8'h3C;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            if (k == 1) begin
                scr_req = 1'b1; scr_addr = 19'h04000;
            end
            @(negedge clk28);
            if (k == 1 || k == 2) check("wr_n_vwr", n_vwr, 1'b0);
            if (k == 1 || k == 2) check("wr_vd_out", vd_out, 8'h3C);
            if (k == 3) check("wr_recover_oe", vd_oe, 1'b1);
            if (k == 3) check("wr_recover_n_vwr", n_vwr, 1'b1);
            if (k == 3) check("wr_cpu_ack", cpu_ack, 1'b1);
            if (k == 4) check("wr_idle_oe", vd_oe, 1'b0);
            if (k == 5) check("wr_scr_n_vrd", n_vrd, 1'b0);
            if (k == 7) check("wr_scr_ack", scr_ack, 1'b1);
            if (k == 7) check("wr_readback", rdata, 8'h3C);
        end
        cpu_we = 1'b0;

        // Starvation, then starved aux preempted by the screen.
        tick();
        cpu_hold = 1'b1;
        cpu_req = 1'b1; cpu_addr = 19'h00400;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 19'h00500;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) tick();
            if (k == 13) aux_req = 1'b1;
            if (k == 21) begin
                scr_req = 1'b1; scr_addr = 19'h00600;
            end
            if (k == 27) cpu_hold = 1'b0;
            @(negedge clk28);
            if (k == 3 || k == 6 || k == 9) check("stv_cpu_ack", cpu_ack, 1'b1);
            if (k == 10) check("stv_aux_va", va, 19'h00500);
            if (k == 12) check("stv_aux_ack", aux_ack, 1'b1);
            if (k == 22) check("stv_scr_preempt", va, 19'h00600);
            if (k == 24) check("stv_scr_ack", scr_ack, 1'b1);
            if (k == 25) check("stv_aux_after_scr", va, 19'h00500);
            if (k == 27) check("stv_aux_ack2", aux_ack, 1'b1);
            if (k == 30) check("stv_cpu_ack_end", cpu_ack, 1'b1);
        end

        // Reset pulsed during the first cycle of an aux write.
        tick();
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 19'h07000; aux_wdata = 8'h99;
        for (int k = 0; k <= 8; k++) begin
            if (k > 0) tick();
            if (k == 1) rst_n = 1'b0;
            if (k == 2) begin
                rst_n = 1'b1; aux_req = 1'b0;
            end
            @(negedge clk28);
            if (k == 1) check("rstw_n_vwr_low", n_vwr, 1'b0);
            if (k == 2) check("rstw_n_vwr_high", n_vwr, 1'b1);
            if (k == 2) check("rstw_vd_oe", vd_oe, 1'b0);
            if (k == 2) check("rstw_va", va, 19'h0);
            if (k >= 2) check("rstw_no_ack", aux_ack, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
